// File: rtl/rx_word_assembler.sv
// Packs four UART bytes (first byte most significant) into a 32-bit word for a
// downstream FIFO. A partial word is dropped if the line stays idle too long.
module rx_word_assembler #(
    parameter int TIMEOUT_CLKS = 4350
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_fifo_full,
    output logic [31:0] o_word_data,
    output logic        o_word_valid,
    output logic [1:0]  o_byte_count,
    output logic        o_timeout,
    output logic        o_overflow
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CLKS - 1);

    state_t      state_q,    state_d;
    logic [1:0]  count_q,    count_d;
    logic [23:0] shift_q,    shift_d;
    logic [15:0] idle_q,     idle_d;
    logic [31:0] word_q,     word_d;
    logic        valid_q,    valid_d;
    logic        timeout_q,  timeout_d;
    logic        overflow_q, overflow_d;

    // Next-state logic: byte collection, word completion and idle timeout.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        idle_d     = idle_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                idle_d = 16'd0;
                if (i_rx_dv) begin
                    shift_d = {16'd0, i_rx_byte};
                    count_d = 2'd1;
                    state_d = ST_COLLECT;
                end else begin
                    count_d = 2'd0;
                end
            end
            ST_COLLECT: begin
                // A byte on the expiry cycle takes priority over the timeout.
                if (i_rx_dv) begin
                    idle_d = 16'd0;
                    if (count_q == 2'd3) begin
                        word_d     = {shift_q, i_rx_byte};
                        valid_d    = ~i_fifo_full;
                        overflow_d = overflow_q | i_fifo_full;
                        count_d    = 2'd0;
                        shift_d    = 24'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        shift_d = {shift_q[15:0], i_rx_byte};
                        count_d = count_q + 2'd1;
                    end
                end else if (idle_q >= IDLE_LAST) begin
                    timeout_d = 1'b1;
                    idle_d    = 16'd0;
                    count_d   = 2'd0;
                    shift_d   = 24'd0;
                    state_d   = ST_IDLE;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 2'd0;
                shift_d = 24'd0;
                idle_d  = 16'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            count_q    <= 2'd0;
            shift_q    <= 24'd0;
            idle_q     <= 16'd0;
            word_q     <= 32'd0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            idle_q     <= idle_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_word_data  = word_q;
    assign o_word_valid = valid_q;
    assign o_byte_count = count_q;
    assign o_timeout    = timeout_q;
    assign o_overflow   = overflow_q;

endmodule
